dma_priority_arbiter: RTL and testbench

- Sequences access to the shared DMA transfer datapath among four channels.
- Forms each channel's effective request from its hardware DREQ, software request and mask bit, then resolves priority (fixed or rotating).
- Runs the HRQ/HLDA hold handshake with the CPU and drives one-hot DACK plus the granted channel number to the timing-control FSM.
- Maintains the priority order register that the rest of the controller reads.

---
 rtl/dma_priority_arbiter.sv | 127 ++++++++++++
 tb/tb_dma_priority_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter: effective-request formation, fixed/rotating
// priority resolution and the HRQ/HLDA hold handshake.
module dma_priority_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              dreqSense,
  input  logic [NUM_CH-1:0] softReq,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic              priorityType,
  input  logic              controllerDisable,
  input  logic              HLDA,
  input  logic              transferDone,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic              grantValid,
  output logic [CH_W-1:0]   grantChannel,
  output logic [7:0]        priorityOrder
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GRANT,
    RELEASE
  } state_t;

  localparam logic [7:0] DefaultOrder = 8'b11_10_01_00;

  state_t            state;
  state_t            stateNext;
  logic [CH_W-1:0]   grantCh;
  logic [CH_W-1:0]   grantChNext;
  logic [CH_W-1:0]   winner;
  logic [NUM_CH-1:0] effReq;
  logic              anyReq;
  logic              completion;
  logic [7:0]        orderNext;

  // Qualify hardware requests by polarity and mask; soft requests bypass mask.
  always_comb begin
    effReq = ((DREQ ^ {NUM_CH{dreqSense}}) & ~maskReg) | softReq;
    if (controllerDisable) effReq = '0;
    anyReq = |effReq;
  end

  // Scan slots lowest-priority first so the highest requesting slot wins.
  always_comb begin
    winner = '0;
    for (int s = NUM_CH - 1; s >= 0; s--) begin
      if (effReq[priorityOrder[s*CH_W +: CH_W]]) begin
        winner = priorityOrder[s*CH_W +: CH_W];
      end
    end
  end

  // Hold handshake sequencing and grant latching.
  always_comb begin
    stateNext   = state;
    grantChNext = grantCh;
    completion  = 1'b0;
    unique case (state)
      IDLE: begin
        if (anyReq) stateNext = REQ;
      end
      REQ: begin
        if (!anyReq) begin
          stateNext = IDLE;
        end else if (HLDA) begin
          stateNext   = GRANT;
          grantChNext = winner;
        end
      end
      GRANT: begin
        if (transferDone) begin
          stateNext  = RELEASE;
          completion = 1'b1;
        end else if (!HLDA) begin
          stateNext = IDLE;
        end
      end
      RELEASE: begin
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Served channel drops to the lowest slot; fixed mode pins the default.
  always_comb begin
    orderNext = priorityOrder;
    if (!priorityType) begin
      orderNext = DefaultOrder;
    end else if (completion) begin
      orderNext = {grantCh,
                   grantCh + CH_W'(3),
                   grantCh + CH_W'(2),
                   grantCh + CH_W'(1)};
    end
  end

  // State, latched channel and priority order registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      grantCh       <= '0;
      priorityOrder <= DefaultOrder;
    end else begin
      state         <= stateNext;
      grantCh       <= grantChNext;
      priorityOrder <= orderNext;
    end
  end

  // Outputs decode the registered state, so reset clears them at once.
  always_comb begin
    HRQ          = (state == REQ) || (state == GRANT);
    grantValid   = (state == GRANT);
    DACK         = '0;
    DACK[grantCh] = grantValid;
    grantChannel = grantValid ? grantCh : '0;
  end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Randomized and directed checks of dma_priority_arbiter against
// a transaction-level reference model.
module tb_dma_priority_arbiter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] DREQ = '0;
  logic       dreqSense = 1'b0;
  logic [3:0] softReq = '0;
  logic [3:0] maskReg = '0;
  logic       priorityType = 1'b0;
  logic       controllerDisable = 1'b0;
  logic       HLDA = 1'b0;
  logic       transferDone = 1'b0;
  logic       HRQ;
  logic [3:0] DACK;
  logic       grantValid;
  logic [1:0] grantChannel;
  logic [7:0] priorityOrder;

  int nTests = 0;
  int nFail = 0;

  bit mReq, mGnt, mRel;
  int mCh;
  int ord[4];

  dma_priority_arbiter dut (
    .CLK(CLK),
    .RESET(RESET),
    .DREQ(DREQ),
    .dreqSense(dreqSense),
    .softReq(softReq),
    .maskReg(maskReg),
    .priorityType(priorityType),
    .controllerDisable(controllerDisable),
    .HLDA(HLDA),
    .transferDone(transferDone),
    .HRQ(HRQ),
    .DACK(DACK),
    .grantValid(grantValid),
    .grantChannel(grantChannel),
    .priorityOrder(priorityOrder)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] packOrd();
    logic [7:0] p;
    p = '0;
    for (int k = 0; k < 4; k++) p[k*2 +: 2] = 2'(ord[k]);
    return p;
  endfunction

  task automatic modelReset();
    mReq = 0;
    mGnt = 0;
    mRel = 0;
    mCh = 0;
    for (int k = 0; k < 4; k++) ord[k] = k;
  endtask

  task automatic modelStep();
    logic [3:0] eff;
    int win;
    bit done;
    eff = ((DREQ ^ {4{dreqSense}}) & ~maskReg) | softReq;
    if (controllerDisable) eff = '0;
    win = -1;
    for (int k = 0; k < 4; k++)
      if (win < 0 && eff[ord[k]]) win = ord[k];
    done = 0;
    if (mGnt) begin
      if (transferDone) begin
        mGnt = 0;
        mRel = 1;
        done = 1;
      end else if (!HLDA) begin
        mGnt = 0;
      end
    end else if (mRel) begin
      mRel = 0;
    end else if (mReq) begin
      if (win < 0) mReq = 0;
      else if (HLDA) begin
        mReq = 0;
        mGnt = 1;
        mCh = win;
      end
    end else if (win >= 0) begin
      mReq = 1;
    end
    if (!priorityType) begin
      for (int k = 0; k < 4; k++) ord[k] = k;
    end else if (done) begin
      for (int k = 0; k < 4; k++) ord[k] = (mCh + 1 + k) % 4;
    end
  endtask

  task automatic checkAll();
    logic [3:0] expDack;
    expDack = mGnt ? 4'(1 << mCh) : 4'b0;
    check("hrq", HRQ, mReq | mGnt);
    check("dack", DACK, expDack);
    check("gv", grantValid, mGnt);
    check("gch", grantChannel, mGnt ? mCh : 0);
    check("order", priorityOrder, packOrd());
  endtask

  task automatic cycle();
    @(posedge CLK);
    modelStep();
    #1;
    checkAll();
  endtask

  task automatic resetPulse();
    RESET = 1'b1;
    #1;
    check("rstDack", DACK, 4'b0);
    check("rstHrq", HRQ, 1'b0);
    check("rstOrder", priorityOrder, 8'b11_10_01_00);
    modelReset();
    RESET = 1'b0;
  endtask

  task automatic waitGrant(input string tag, input logic [3:0] exp);
    for (int i = 0; i < 10 && DACK == 4'b0; i++) cycle();
    check(tag, DACK, exp);
  endtask

  initial begin
    modelReset();
    repeat (2) @(posedge CLK);
    #1;
    checkAll();
    RESET = 1'b0;

    // Fixed priority
    DREQ = 4'b1010;
    HLDA = 1'b1;
    cycle();
    check("fixHrq", HRQ, 1'b1);
    check("fixDack0", DACK, 4'b0);
    cycle();
    check("fixDack", DACK, 4'b0010);
    check("fixCh", grantChannel, 2'd1);
    transferDone = 1'b1;
    DREQ = 4'b1000;
    cycle();
    transferDone = 1'b0;
    check("relHrq", HRQ, 1'b0);
    waitGrant("fixDack2", 4'b1000);
    DREQ = 4'b0;
    transferDone = 1'b1;
    cycle();
    transferDone = 1'b0;
    repeat (2) cycle();

    // Rotating priority
    priorityType = 1'b1;
    DREQ = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      waitGrant("rotDack", 4'(1 << (n % 4)));
      transferDone = 1'b1;
      cycle();
      transferDone = 1'b0;
      if (n == 0) check("rotOrder", priorityOrder, 8'b00_11_10_01);
    end

    // Reset mid-grant with a rotated order
    DREQ = 4'b0100;
    repeat (2) cycle();
    waitGrant("preRst", 4'b0100);
    resetPulse();
    DREQ = 4'b0;
    priorityType = 1'b0;
    cycle();

    // Masking, soft request, polarity
    maskReg = 4'b0001;
    DREQ = 4'b0001;
    repeat (3) cycle();
    check("maskHrq", HRQ, 1'b0);
    softReq = 4'b0001;
    waitGrant("softDack", 4'b0001);
    softReq = 4'b0;
    maskReg = 4'b0;
    DREQ = 4'b0;
    transferDone = 1'b1;
    cycle();
    transferDone = 1'b0;
    cycle();
    dreqSense = 1'b1;
    DREQ = 4'b1110;
    waitGrant("senseDack", 4'b0001);
    dreqSense = 1'b0;
    DREQ = 4'b0;
    transferDone = 1'b1;
    cycle();
    transferDone = 1'b0;
    repeat (2) cycle();

    // Late higher-priority request while waiting for HLDA
    HLDA = 1'b0;
    DREQ = 4'b1000;
    repeat (3) cycle();
    check("lateHrq", HRQ, 1'b1);
    DREQ = 4'b1001;
    cycle();
    HLDA = 1'b1;
    waitGrant("lateDack", 4'b0001);

    // HLDA abort
    HLDA = 1'b0;
    DREQ = 4'b0;
    cycle();
    check("abortDack", DACK, 4'b0);
    check("abortHrq", HRQ, 1'b0);
    check("abortOrder", priorityOrder, 8'b11_10_01_00);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      DREQ = 4'($urandom);
      if ($urandom_range(0, 15) == 0) dreqSense = ~dreqSense;
      softReq = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      maskReg = 4'($urandom);
      if ($urandom_range(0, 29) == 0) priorityType = ~priorityType;
      controllerDisable = ($urandom_range(0, 9) == 0);
      HLDA = ($urandom_range(0, 3) != 0);
      transferDone = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
